// File: rtl/fd_pipe.sv
// Parametrised registered delay line with per-stage valid bits, clock enable,
// synchronous flush, a runtime-selectable output tap and an occupancy counter.
module fd_pipe #(
  parameter int                 WIDTH     = 8,
  parameter int                 DEPTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  localparam int                SW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int                CW        = $clog2(DEPTH + 1)
) (
  input  logic             CK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             CLR,
  input  logic [WIDTH-1:0] I,
  input  logic             IV,
  input  logic [SW-1:0]    SEL,
  output logic [WIDTH-1:0] O,
  output logic             OV,
  output logic [CW-1:0]    CNT
);

  logic [WIDTH-1:0] stageData_q [DEPTH];
  logic [WIDTH-1:0] stageData_d [DEPTH];
  logic [DEPTH-1:0] stageValid_q;
  logic [DEPTH-1:0] stageValid_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [SW-1:0]    selClamp;

  // Flush beats shift; the count tracks words entering S[0] and leaving S[DEPTH-1].
  always_comb begin
    stageData_d  = stageData_q;
    stageValid_d = stageValid_q;
    count_d      = count_q;
    if (CLR) begin
      for (int k = 0; k < DEPTH; k++) begin
        stageData_d[k]  = RESET_VAL;
        stageValid_d[k] = 1'b0;
      end
      count_d = '0;
    end else if (CE) begin
      stageData_d[0]  = I;
      stageValid_d[0] = IV;
      for (int k = 1; k < DEPTH; k++) begin
        stageData_d[k]  = stageData_q[k-1];
        stageValid_d[k] = stageValid_q[k-1];
      end
      count_d = count_q + CW'(IV) - CW'(stageValid_q[DEPTH-1]);
    end
  end

  always_ff @(posedge CK) begin
    if (!RST_N) begin
      for (int k = 0; k < DEPTH; k++) begin
        stageData_q[k] <= RESET_VAL;
      end
      stageValid_q <= '0;
      count_q      <= '0;
    end else begin
      stageData_q  <= stageData_d;
      stageValid_q <= stageValid_d;
      count_q      <= count_d;
    end
  end

  // Out-of-range selects (non power-of-two DEPTH) fall back to the last stage.
  always_comb begin
    selClamp = SEL;
    if (int'(SEL) > DEPTH - 1) begin
      selClamp = SW'(DEPTH - 1);
    end
  end

  assign O   = stageData_q[selClamp];
  assign OV  = stageValid_q[selClamp];
  assign CNT = count_q;

endmodule

// File: tb/tb_fd_pipe.sv
// Self-checking bench for fd_pipe: a DEPTH=4 and a DEPTH=3 instance share one
// stimulus stream and are compared each cycle against a history-based model.
module tb_fd_pipe;

  localparam logic [7:0] RV4 = 8'h00;
  localparam logic [7:0] RV3 = 8'h5A;

  logic       CK = 1'b0;
  logic       RST_N, CE, CLR, IV;
  logic [7:0] I;
  logic [1:0] SEL;

  logic [7:0] O4, O3;
  logic       OV4, OV3;
  logic [2:0] CNT4;
  logic [1:0] CNT3;

  int checks = 0;
  int errors = 0;
  logic checkingOn = 1'b0;

  // Accepted words since the last flush, newest first, trimmed to DEPTH.
  logic [7:0] hist4D[$];
  bit         hist4V[$];
  logic [7:0] hist3D[$];
  bit         hist3V[$];

  always #5 CK = ~CK;

  fd_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV4)) dut4 (
    .CK(CK), .RST_N(RST_N), .CE(CE), .CLR(CLR), .I(I), .IV(IV), .SEL(SEL),
    .O(O4), .OV(OV4), .CNT(CNT4)
  );

  fd_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(RV3)) dut3 (
    .CK(CK), .RST_N(RST_N), .CE(CE), .CLR(CLR), .I(I), .IV(IV), .SEL(SEL),
    .O(O3), .OV(OV3), .CNT(CNT3)
  );

  function automatic int clampSel(int s, int d);
    return (s > d - 1) ? d - 1 : s;
  endfunction

  function automatic logic [7:0] expO4();
    int s = clampSel(int'(SEL), 4);
    return (s < hist4D.size()) ? hist4D[s] : RV4;
  endfunction

  function automatic bit expOV4();
    int s = clampSel(int'(SEL), 4);
    return (s < hist4V.size()) ? hist4V[s] : 1'b0;
  endfunction

  function automatic logic [7:0] expO3();
    int s = clampSel(int'(SEL), 3);
    return (s < hist3D.size()) ? hist3D[s] : RV3;
  endfunction

  function automatic bit expOV3();
    int s = clampSel(int'(SEL), 3);
    return (s < hist3V.size()) ? hist3V[s] : 1'b0;
  endfunction

  function automatic int expCnt4();
    int n = 0;
    foreach (hist4V[k]) n += int'(hist4V[k]);
    return n;
  endfunction

  function automatic int expCnt3();
    int n = 0;
    foreach (hist3V[k]) n += int'(hist3V[k]);
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: reset/flush empties the history, an enabled edge pushes one word.
  always @(posedge CK) begin
    if (!RST_N || CLR) begin
      hist4D.delete(); hist4V.delete();
      hist3D.delete(); hist3V.delete();
    end else if (CE) begin
      hist4D.push_front(I); hist4V.push_front(IV);
      hist3D.push_front(I); hist3V.push_front(IV);
      if (hist4D.size() > 4) begin void'(hist4D.pop_back()); void'(hist4V.pop_back()); end
      if (hist3D.size() > 3) begin void'(hist3D.pop_back()); void'(hist3V.pop_back()); end
    end
  end

  always @(negedge CK) begin
    if (checkingOn) begin
      checkOutput("model_O4",   32'(O4),   32'(expO4()));
      checkOutput("model_OV4",  32'(OV4),  32'(expOV4()));
      checkOutput("model_CNT4", 32'(CNT4), 32'(expCnt4()));
      checkOutput("model_O3",   32'(O3),   32'(expO3()));
      checkOutput("model_OV3",  32'(OV3),  32'(expOV3()));
      checkOutput("model_CNT3", 32'(CNT3), 32'(expCnt3()));
    end
  end

  task automatic step();
    @(posedge CK);
    #2;
  endtask

  task automatic applyStimulus(input logic rstN, input logic ce, input logic clr,
                               input logic iv, input logic [7:0] din);
    RST_N = rstN; CE = ce; CLR = clr; IV = iv; I = din;
    step();
  endtask

  initial begin
    RST_N = 1'b0; CE = 1'b1; CLR = 1'b0; IV = 1'b1; I = 8'hFF; SEL = 2'd0;

    // Reset held two edges with active input traffic
    for (int e = 0; e < 2; e++) begin
      step();
      checkingOn = 1'b1;
      checkOutput("rst_O4",   32'(O4),   32'h00);
      checkOutput("rst_OV4",  32'(OV4),  32'h0);
      checkOutput("rst_CNT4", 32'(CNT4), 32'h0);
      checkOutput("rst_O3",   32'(O3),   32'h5A);
      checkOutput("rst_OV3",  32'(OV3),  32'h0);
    end

    // SEL=0: one-edge latency
    applyStimulus(1, 1, 0, 1, 8'hA5);
    checkOutput("lat0_O4",  32'(O4),   32'hA5);
    checkOutput("lat0_OV4", 32'(OV4),  32'h1);
    checkOutput("lat0_CNT", 32'(CNT4), 32'h1);

    // SEL=3: four-edge latency, DUT3 clamps to tap 2
    applyStimulus(0, 1, 0, 0, 8'h00);
    SEL = 2'd3;
    applyStimulus(1, 1, 0, 1, 8'hA5);
    checkOutput("lat3_e1_OV4", 32'(OV4), 32'h0);
    applyStimulus(1, 1, 0, 0, 8'h3C);
    checkOutput("lat3_e2_OV4", 32'(OV4), 32'h0);
    applyStimulus(1, 1, 0, 0, 8'h3C);
    checkOutput("lat3_e3_OV4", 32'(OV4), 32'h0);
    checkOutput("clamp_e3_O3",  32'(O3),  32'hA5);
    checkOutput("clamp_e3_OV3", 32'(OV3), 32'h1);
    applyStimulus(1, 1, 0, 0, 8'h3C);
    checkOutput("lat3_e4_O4",  32'(O4),  32'hA5);
    checkOutput("lat3_e4_OV4", 32'(OV4), 32'h1);

    // Stall then drain
    applyStimulus(0, 1, 0, 0, 8'h00);
    SEL = 2'd0;
    applyStimulus(1, 1, 0, 1, 8'h11);
    applyStimulus(1, 1, 0, 1, 8'h22);
    checkOutput("stall_pre_CNT", 32'(CNT4), 32'h2);
    for (int e = 0; e < 3; e++) begin
      applyStimulus(1, 0, 0, 1, 8'h99);
      checkOutput("stall_CNT", 32'(CNT4), 32'h2);
      checkOutput("stall_O4",  32'(O4),   32'h22);
      checkOutput("stall_OV4", 32'(OV4),  32'h1);
    end
    begin
      int drainCnt [4] = '{2, 2, 1, 0};
      for (int e = 0; e < 4; e++) begin
        applyStimulus(1, 1, 0, 0, 8'h00);
        checkOutput("drain_CNT", 32'(CNT4), 32'(drainCnt[e]));
      end
    end

    // Flush wins over a concurrent valid input
    applyStimulus(1, 1, 0, 1, 8'h01);
    applyStimulus(1, 1, 0, 1, 8'h02);
    applyStimulus(1, 1, 0, 1, 8'h03);
    checkOutput("flush_pre_CNT", 32'(CNT4), 32'h3);
    applyStimulus(1, 1, 1, 1, 8'hEE);
    checkOutput("flush_CNT4", 32'(CNT4), 32'h0);
    checkOutput("flush_OV4",  32'(OV4),  32'h0);
    checkOutput("flush_O4",   32'(O4),   32'h00);
    checkOutput("flush_O3",   32'(O3),   32'h5A);
    applyStimulus(1, 1, 0, 1, 8'h77);
    checkOutput("postflush_CNT", 32'(CNT4), 32'h1);
    checkOutput("postflush_O4",  32'(O4),   32'h77);

    // Continuous traffic: counts saturate at DEPTH
    SEL = 2'd3;
    for (int e = 0; e < 10; e++) begin
      applyStimulus(1, 1, 0, 1, 8'h40 + 8'(e));
    end
    checkOutput("sat_CNT4", 32'(CNT4), 32'h4);
    checkOutput("sat_CNT3", 32'(CNT3), 32'h3);
    checkOutput("sat_O3",   32'(O3),   32'h47);
    checkOutput("sat_O4",   32'(O4),   32'h46);

    // Reset beats everything else on the same edge
    applyStimulus(0, 1, 0, 1, 8'hC3);
    checkOutput("rstwin_CNT4", 32'(CNT4), 32'h0);
    checkOutput("rstwin_CNT3", 32'(CNT3), 32'h0);

    // Tap change mid-stream is combinational and leaves contents intact
    applyStimulus(1, 1, 0, 1, 8'h10);
    applyStimulus(1, 1, 0, 1, 8'h20);
    applyStimulus(1, 1, 0, 1, 8'h30);
    applyStimulus(1, 1, 0, 1, 8'h40);
    CE = 1'b0;
    checkOutput("tap3_O4", 32'(O4), 32'h10);
    SEL = 2'd1;
    #1;
    checkOutput("tap1_O4", 32'(O4), 32'h30);
    checkOutput("tap1_O3", 32'(O3), 32'h30);
    step();
    SEL = 2'd3;
    #1;
    checkOutput("tap3_back_O4", 32'(O4), 32'h10);
    step();

    checkingOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
